// File: rtl/ufm_pkg.sv
// ufm_pkg: shared states, op/error codes and CSR bit positions for the UFM CSR sequencer.
package ufm_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WP_WR, S_WP_RD, S_WP_CHK, S_CMD_WR, S_POLL_RD, S_POLL_CHK,
    S_END_WR, S_IDLE_RD, S_IDLE_CHK, S_PROT_WR, S_DONE, S_ERR
  } state_e;
  typedef enum logic [1:0] {
    OP_SECTOR_ERASE, OP_PAGE_ERASE, OP_UNPROTECT, OP_PROTECT_ALL
  } op_e;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_WP      = 3'd1;
  localparam logic [2:0] ERR_ERASE   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_SECTOR  = 3'd4;
  localparam int CT_SEC_LSB  = 20;
  localparam int CT_WP_LSB   = 23;
  localparam int ST_OK_BIT   = 4;
  localparam int ST_WP_LSB   = 5;
  localparam logic [31:0] CTRL_RESET = 32'hFFFF_FFFF;
  // Sector s (1-based) owns WP bit CT_WP_LSB + s - 1.
  function automatic logic [31:0] ctrl_wp_clear(input logic [31:0] c, input logic [2:0] s);
    return c & ~(32'd1 << (5'(CT_WP_LSB - 1) + 5'(s)));
  endfunction
endpackage

// File: rtl/ufm_csr_port.sv
// ufm_csr_port: single-cycle CSR strobes with a mandatory idle gap, read-latency pipe and readdata capture.
module ufm_csr_port
  import ufm_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        csr_addr,
  output logic        csr_read,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata
);
  logic [READ_LATENCY:0] rd_pipe_q;
  logic                  gap_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  free;
  // The top pipe bit marks the cycle after capture, when rdata is usable.
  always_comb begin
    free          = !gap_q && rd_pipe_q == '0;
    csr_read      = req_rd && free;
    csr_write     = req_wr && free && !req_rd;
    csr_addr      = csr_write;
    csr_writedata = csr_write ? wdata : wdata_q;
    ack           = csr_write || rd_pipe_q[READ_LATENCY];
    rdata         = rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe_q <= '0;
      gap_q     <= 1'b0;
      wdata_q   <= CTRL_RESET;
      rdata_q   <= '0;
    end else begin
      rd_pipe_q <= {rd_pipe_q[READ_LATENCY-1:0], csr_read};
      gap_q     <= csr_read || csr_write;
      if (csr_write) wdata_q <= wdata;
      if (rd_pipe_q[READ_LATENCY-1]) rdata_q <= csr_readdata;
    end
  end
endmodule

// File: rtl/ufm_csr_sequencer.sv
// ufm_csr_sequencer: runs erase / unprotect / re-protect operations on the MAX10 UFM CSR slave.
module ufm_csr_sequencer
  import ufm_pkg::*;
#(
  parameter int SECTOR_COUNT   = 5,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int REPROTECT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [2:0]  sector,
  input  logic [19:0] page_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        csr_addr,
  output logic        csr_read,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Give up as soon as one more poll round could no longer finish inside the budget.
  localparam int TMO_LIM = TIMEOUT_CYCLES > READ_LATENCY + 3 ? TIMEOUT_CYCLES - READ_LATENCY - 3 : 0;
  localparam logic [TW-1:0] TMO_LAST = TMO_LIM[TW-1:0];
  localparam logic [2:0] SEC_MAX = SECTOR_COUNT[2:0];
  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [2:0]    sec_q, sec_d;
  logic [19:0]   page_q, page_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [2:0]    code_q, code_d;
  logic          seen_busy_q, seen_busy_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          req_rd, req_wr, ack;
  logic [31:0]   wdata, rdata;
  logic          st_busy, st_ok, st_wp, tmo_hit, bad_sec, unused_rdata;
  ufm_csr_port #(.READ_LATENCY(READ_LATENCY)) u_port (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .csr_addr(csr_addr), .csr_read(csr_read),
    .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
  );
  assign st_busy      = rdata[1:0] != 2'b00;
  assign st_ok        = rdata[ST_OK_BIT];
  assign st_wp        = rdata[5'(ST_WP_LSB - 1) + 5'(sec_q)];
  assign tmo_hit      = tmo_q >= TMO_LAST;
  assign bad_sec      = sector == 3'd0 || sector > SEC_MAX;
  assign unused_rdata = ^{rdata[31:10], rdata[3:2]};
  assign busy         = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done         = state_q == S_DONE;
  assign error        = state_q == S_ERR;
  assign err_code     = code_q;
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sec_d       = sec_q;
    page_d      = page_q;
    shadow_d    = shadow_q;
    code_d      = code_q;
    seen_busy_d = seen_busy_q;
    tmo_d       = tmo_q + 1'b1;
    req_rd      = 1'b0;
    req_wr      = 1'b0;
    wdata       = shadow_q;
    case (state_q)
      S_IDLE: if (start) begin
        op_d    = op_e'(op);
        sec_d   = sector;
        page_d  = page_addr;
        code_d  = (op != OP_PROTECT_ALL && bad_sec) ? ERR_SECTOR : ERR_NONE;
        state_d = op == OP_PROTECT_ALL ? S_PROT_WR : bad_sec ? S_ERR : S_WP_WR;
      end
      S_WP_WR: begin
        req_wr = 1'b1;
        wdata  = ctrl_wp_clear(shadow_q, sec_q);
        if (ack) begin
          shadow_d = wdata;
          state_d  = S_WP_RD;
        end
      end
      S_WP_RD: begin
        req_rd  = 1'b1;
        state_d = ack ? S_WP_CHK : S_WP_RD;
      end
      S_WP_CHK: begin
        code_d  = st_wp ? ERR_WP : code_q;
        state_d = st_wp ? S_END_WR : op_q == OP_UNPROTECT ? S_DONE : S_CMD_WR;
      end
      S_CMD_WR: begin
        req_wr = 1'b1;
        wdata  = op_q == OP_PAGE_ERASE ? {shadow_q[31:CT_WP_LSB], 3'b111, page_q}
                                       : {shadow_q[31:CT_WP_LSB], sec_q, shadow_q[CT_SEC_LSB-1:0]};
        if (ack) begin
          shadow_d    = wdata;
          seen_busy_d = 1'b0;
          tmo_d       = '0;
          state_d     = S_POLL_RD;
        end
      end
      S_POLL_RD: begin
        req_rd  = 1'b1;
        state_d = ack ? S_POLL_CHK : S_POLL_RD;
      end
      S_POLL_CHK: begin
        seen_busy_d = seen_busy_q || st_busy;
        if (!st_busy && (seen_busy_q || st_ok)) begin
          code_d  = st_ok ? code_q : ERR_ERASE;
          state_d = S_END_WR;
        end else if (tmo_hit) begin
          code_d  = ERR_TIMEOUT;
          state_d = S_END_WR;
        end else begin
          state_d = S_POLL_RD;
        end
      end
      S_END_WR: begin
        req_wr = 1'b1;
        wdata  = {shadow_q[31:CT_WP_LSB], 23'h7F_FFFF};
        if (ack) begin
          shadow_d = wdata;
          tmo_d    = '0;
          state_d  = S_IDLE_RD;
        end
      end
      S_IDLE_RD: begin
        req_rd  = 1'b1;
        state_d = ack ? S_IDLE_CHK : S_IDLE_RD;
      end
      S_IDLE_CHK: begin
        if (!st_busy) begin
          state_d = (REPROTECT != 0 || code_q != ERR_NONE) ? S_PROT_WR : S_DONE;
        end else if (tmo_hit) begin
          code_d  = code_q != ERR_NONE ? code_q : ERR_TIMEOUT;
          state_d = S_PROT_WR;
        end else begin
          state_d = S_IDLE_RD;
        end
      end
      S_PROT_WR: begin
        req_wr = 1'b1;
        wdata  = shadow_q | (32'h1F << CT_WP_LSB);
        if (ack) begin
          shadow_d = wdata;
          state_d  = code_q != ERR_NONE ? S_ERR : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SECTOR_ERASE;
      sec_q       <= '0;
      page_q      <= '0;
      shadow_q    <= CTRL_RESET;
      code_q      <= ERR_NONE;
      seen_busy_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sec_q       <= sec_d;
      page_q      <= page_d;
      shadow_q    <= shadow_d;
      code_q      <= code_d;
      seen_busy_q <= seen_busy_d;
      tmo_q       <= tmo_d;
    end
  end
endmodule

// File: tb/tb_ufm_csr_sequencer.sv
// tb_ufm_csr_sequencer: directed checks of the UFM CSR sequencer against a small behavioural flash CSR model.
module tb_ufm_csr_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0]  op = '0;
  logic [2:0]  sector = '0;
  logic [19:0] page_addr = '0;
  logic        busy, done, error, csr_addr, csr_read, csr_write;
  logic [2:0]  err_code;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata = '0;
  int          n_vec = 0, n_bad = 0;
  logic [31:0] ctrl_m = 32'hFFFF_FFFF;
  int          busy_cnt = 0, wr_n = 0, rd_n = 0;
  logic        ok_m = 1'b0, busy_forever = 1'b0, wp_stuck = 1'b0;
  logic        prev_strobe = 1'b0, spacing_bad = 1'b0;
  logic [31:0] wr_log [0:63];
  logic [31:0] status_m;

  always #5 clk = ~clk;

  ufm_csr_sequencer #(.SECTOR_COUNT(5), .READ_LATENCY(1), .TIMEOUT_CYCLES(100), .REPROTECT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .sector(sector), .page_addr(page_addr),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .csr_addr(csr_addr),
    .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata)
  );

  // Flash model: WP status follows the last control write, any erase command keeps busy=01 for 50 cycles.
  assign status_m = {22'd0, ctrl_m[27:23] | {4'd0, wp_stuck}, ok_m, 2'b00,
                     (busy_forever || busy_cnt != 0) ? 2'b01 : 2'b00};

  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (busy_cnt == 1) ok_m <= 1'b1;
    if (csr_read) begin
      csr_readdata <= status_m;
      rd_n <= rd_n + 1;
    end
    if (csr_write) begin
      ctrl_m <= csr_writedata;
      wr_log[wr_n] <= csr_writedata;
      wr_n <= wr_n + 1;
      if (csr_writedata[22:20] != 3'b111 || csr_writedata[19:0] != 20'hFFFFF) begin
        busy_cnt <= 50;
        ok_m <= 1'b0;
      end
    end
    if ((csr_read || csr_write) && (prev_strobe || (csr_read && csr_write))) spacing_bad <= 1'b1;
    prev_strobe <= csr_read || csr_write;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [2:0] s, input logic [19:0] p,
                        output int lat, output logic [1:0] ev, output logic [2:0] code);
    @(negedge clk);
    op = o; sector = s; page_addr = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && !error && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    ev = {done, error};
    code = err_code;
  endtask

  initial begin
    int lat, k, base, strobes;
    logic [1:0] ev;
    logic [2:0] code;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, error, err_code, csr_addr, csr_read, csr_write}, 0);
    check("reset_wdata", csr_writedata, 32'hFFFF_FFFF);
    rst = 1'b0;

    base = wr_n;
    run_op(2'b00, 3'd2, 20'h0, lat, ev, code);
    check("se_done", ev, 2'b10);
    check("se_code", code, 0);
    check("se_nwr", wr_n - base, 4);
    check("se_wr0", wr_log[base], 32'hFEFF_FFFF);
    check("se_wr1", wr_log[base+1], 32'hFEAF_FFFF);
    check("se_wr2", wr_log[base+2], 32'hFEFF_FFFF);
    check("se_wr3", wr_log[base+3], 32'hFFFF_FFFF);

    base = wr_n;
    run_op(2'b01, 3'd3, 20'h01234, lat, ev, code);
    check("pe_done", ev, 2'b10);
    check("pe_cmd", wr_log[base+1], 32'hFDF0_1234);

    base = wr_n;
    wp_stuck = 1'b1;
    run_op(2'b00, 3'd1, 20'h0, lat, ev, code);
    wp_stuck = 1'b0;
    check("wp_error", ev, 2'b01);
    check("wp_code", code, 1);
    check("wp_nwr", wr_n - base, 3);
    check("wp_last", wr_log[wr_n-1], 32'hFFFF_FFFF);

    strobes = wr_n + rd_n;
    run_op(2'b00, 3'd0, 20'h0, lat, ev, code);
    check("bad0_error", ev, 2'b01);
    check("bad0_code", code, 4);
    run_op(2'b00, 3'd6, 20'h0, lat, ev, code);
    check("bad6_error", ev, 2'b01);
    check("bad6_code", code, 4);
    check("bad_strobes", wr_n + rd_n - strobes, 0);

    base = wr_n;
    busy_forever = 1'b1;
    @(negedge clk);
    op = 2'b00; sector = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (wr_n < base + 2 && k < 100) begin @(negedge clk); k++; end
    k = 0;
    while (err_code != 3'd3 && k < 300) begin @(negedge clk); k++; end
    check("tmo_window", k >= 90 && k <= 100, 1);
    k = 0;
    while (!error && k < 1000) begin @(negedge clk); k++; end
    check("tmo_error", error, 1);
    check("tmo_code", err_code, 3);
    check("tmo_end_wr", wr_log[base+2], 32'hFEFF_FFFF);
    check("tmo_prot_wr", wr_log[base+3], 32'hFFFF_FFFF);
    busy_forever = 1'b0;

    base = wr_n;
    @(negedge clk);
    op = 2'b00; sector = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (wr_n < base + 2 && k < 100) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_outputs", {busy, done, error, err_code, csr_addr, csr_read, csr_write}, 0);
    check("rst_wdata", csr_writedata, 32'hFFFF_FFFF);
    run_op(2'b10, 3'd3, 20'h0, lat, ev, code);
    check("unp_done", ev, 2'b10);
    check("unp_latency", lat, 7);

    base = wr_n;
    run_op(2'b11, 3'd0, 20'h0, lat, ev, code);
    check("prot_done", ev, 2'b10);
    check("prot_latency", lat, 2);
    check("prot_wr", wr_log[base], 32'hFFFF_FFFF);

    check("strobe_spacing", spacing_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
